simd_serial_sub: RTL and testbench

SIMD_SERIAL_SUB -- requirements
Module: simd_serial_sub

---
 rtl/simd_serial_sub_pkg.sv | 57 +++++
 rtl/simd_serial_sub_sub32_w_b.sv | 21 ++
 rtl/simd_serial_sub.sv | 106 ++++++++++
 tb/tb_simd_serial_sub.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/simd_serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simd_serial_sub_pkg (TYPES, FUNCS, simd_serial_sub_pkg)
// Description : Shared types, lane-mask helpers and FSM encoding for the
//               chunk-serial SIMD subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package TYPES;
    typedef logic [255:0] prng_t;
    typedef logic [2:0]   width_t;   // {is256, is128, is64}

    typedef struct packed {
        logic        borrow;
        logic [31:0] value;
    } u32_w_c_t;
endpackage

package FUNCS;
    import TYPES::*;

    // One bit per 32-bit boundary: set where a carry must NOT ripple across.
    function automatic logic [255:0] make_carry_mask(input width_t w);
        logic [255:0] m;
        m = '0;
        for (int k = 1; k < 8; k++) begin
            if ((k % 2) == 1)
                m[32*k] = ~w[0];
            else if (k == 4)
                m[32*k] = ~w[2];
            else
                m[32*k] = ~w[1];
        end
        return m;
    endfunction

    function automatic logic [7:0] make_lane_start(input width_t w);
        logic [255:0] m;
        logic [7:0]   s;
        m    = make_carry_mask(w);
        s    = '0;
        s[0] = 1'b1;
        for (int k = 1; k < 8; k++)
            s[k] = m[32*k];
        return s;
    endfunction
endpackage

package simd_serial_sub_pkg;
    localparam int C_NUM_CHUNKS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage
`default_nettype wire

// File: rtl/simd_serial_sub_sub32_w_b.sv
`default_nettype none
// ============================================================================
// Module      : sub32_w_b
// Description : Combinational 32-bit subtract with borrow-in and borrow-out.
// Revision    : 1.0 - initial release
// ============================================================================
module sub32_w_b
    import TYPES::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_borrow,
    output u32_w_c_t    o_res
);
    logic [32:0] w_diff;

    // The 33rd bit of the extended difference is the borrow-out.
    assign w_diff = {1'b0, i_a} - {1'b0, i_b} - {32'd0, i_borrow};
    assign o_res  = u32_w_c_t'(w_diff);
endmodule
`default_nettype wire

// File: rtl/simd_serial_sub.sv
`default_nettype none
// ============================================================================
// Module      : simd_serial_sub
// Description : 256-bit SIMD subtractor (32/64/128/256-bit lanes) processing
//               one 32-bit chunk per cycle with a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module simd_serial_sub
    import TYPES::*;
    import FUNCS::*;
    import simd_serial_sub_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_i,
    output logic       ready_o,
    input  prng_t      a_i,
    input  prng_t      b_i,
    input  width_t     width_i,
    output logic       valid_o,
    input  logic       ready_i,
    output prng_t      diff_o,
    output logic [7:0] borrow_o
);
    state_t     r_state;
    prng_t      r_a;
    prng_t      r_b;
    width_t     r_width;
    logic [2:0] r_cnt;
    logic       r_borrow;

    logic [7:0]  w_lane_start;
    logic [7:0]  w_lane_end;
    logic [7:0]  w_base;
    logic        w_borrow_in;
    u32_w_c_t    w_res;

    assign w_lane_start = make_lane_start(r_width);
    // A chunk ends its lane when the next chunk starts one, or it is the top chunk.
    assign w_lane_end   = {1'b1, w_lane_start[7:1]};
    assign w_base       = {r_cnt, 5'd0};
    assign w_borrow_in  = w_lane_start[r_cnt] ? 1'b0 : r_borrow;

    sub32_w_b u_sub (
        .i_a      (r_a[w_base +: 32]),
        .i_b      (r_b[w_base +: 32]),
        .i_borrow (w_borrow_in),
        .o_res    (w_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_width  <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            ready_o  <= 1'b0;
            valid_o  <= 1'b0;
            diff_o   <= '0;
            borrow_o <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (valid_i && ready_o) begin
                        r_a      <= a_i;
                        r_b      <= b_i;
                        r_width  <= width_i;
                        r_cnt    <= '0;
                        r_borrow <= 1'b0;
                        diff_o   <= '0;
                        borrow_o <= '0;
                        ready_o  <= 1'b0;
                        r_state  <= ST_BUSY;
                    end else begin
                        ready_o  <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    diff_o[w_base +: 32] <= w_res.value;
                    borrow_o[r_cnt]      <= w_res.borrow & w_lane_end[r_cnt];
                    r_borrow             <= w_res.borrow;
                    r_cnt                <= r_cnt + 3'd1;
                    if (r_cnt == 3'(C_NUM_CHUNKS - 1)) begin
                        valid_o <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    valid_o <= 1'b0;
                    ready_o <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_simd_serial_sub.sv
`default_nettype none
// ============================================================================
// Module      : tb_simd_serial_sub
// Description : Self-checking bench for simd_serial_sub.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simd_serial_sub;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid_i = 1'b0;
    logic         ready_o;
    logic [255:0] a_i = '0;
    logic [255:0] b_i = '0;
    logic [2:0]   width_i = '0;
    logic         valid_o;
    logic         ready_i = 1'b0;
    logic [255:0] diff_o;
    logic [7:0]   borrow_o;

    int n_checks = 0;
    int n_pass   = 0;

    simd_serial_sub dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .a_i      (a_i),
        .b_i      (b_i),
        .width_i  (width_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .diff_o   (diff_o),
        .borrow_o (borrow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] a;
        logic [255:0] b;
        logic [2:0]   w;
        logic [255:0] d;
        logic [7:0]   br;
    } vec_t;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Lane-level reference: whole-lane modular subtraction and borrow = a<b.
    function automatic void ref_model(input logic [255:0] a, input logic [255:0] b,
                                      input logic [2:0] w,
                                      output logic [255:0] d, output logic [7:0] br);
        int           lw;
        logic [256:0] mask, la, lb, ld;
        lw = (w == 3'b111) ? 256 : (w == 3'b011) ? 128 : (w == 3'b001) ? 64 : 32;
        d  = '0;
        br = '0;
        mask = (257'd1 << lw) - 257'd1;
        for (int lo = 0; lo < 256; lo += lw) begin
            la = ({1'b0, a} >> lo) & mask;
            lb = ({1'b0, b} >> lo) & mask;
            ld = (la - lb) & mask;
            d  = d | (ld[255:0] << lo);
            br[(lo + lw) / 32 - 1] = (la < lb);
        end
    endfunction

    // Issues one request; scrambles inputs after acceptance; optionally stalls
    // the output with ready_i low (toggling valid_i/a_i when tog is set).
    task automatic run_req(input logic [255:0] a, input logic [255:0] b, input logic [2:0] w,
                           input int stall, input bit tog,
                           output logic [255:0] d, output logic [7:0] br, output int lat);
        int guard;
        guard = 0;
        while (!ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!ready_o) chk("ready_wait_timeout", 256'(ready_o), 256'd1);
        a_i = a; b_i = b; width_i = w; valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        a_i = rand256(); b_i = rand256(); width_i = 3'($urandom);
        lat = 1;
        while (!valid_o && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!valid_o) chk("valid_wait_timeout", 256'(valid_o), 256'd1);
        d  = diff_o;
        br = borrow_o;
        ready_i = 1'b0;
        for (int s = 0; s < stall; s++) begin
            if (tog) begin
                valid_i = ~valid_i;
                a_i = rand256();
            end
            @(negedge clk);
            chk("stall_diff_stable", diff_o, d);
            chk("stall_borrow_stable", 256'(borrow_o), 256'(br));
            chk("stall_valid_held", 256'(valid_o), 256'd1);
            if (tog) chk("stall_ready_low", 256'(ready_o), 256'd0);
        end
        ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ready_i = 1'b0;
        valid_i = 1'b0;
        chk("post_handshake_valid_low", 256'(valid_o), 256'd0);
        chk("post_handshake_ready", 256'(ready_o), 256'd1);
    endtask

    initial begin
        vec_t         vecs[5];
        logic [255:0] d, ed;
        logic [7:0]   br, ebr;
        int           lat;
        logic [2:0]   legal[4];

        legal[0] = 3'b000; legal[1] = 3'b001; legal[2] = 3'b011; legal[3] = 3'b111;

        vecs[0] = '{'0, {8{32'h1}}, 3'b000, {8{32'hFFFFFFFF}}, 8'hFF};
        vecs[1] = '{'0, {8{32'h1}}, 3'b001, {4{64'hFFFFFFFE_FFFFFFFF}}, 8'hAA};
        vecs[2] = '{'0, {8{32'h1}}, 3'b011,
                    {2{128'hFFFFFFFE_FFFFFFFE_FFFFFFFE_FFFFFFFF}}, 8'h88};
        vecs[3] = '{'0, {8{32'h1}}, 3'b111,
                    {{7{32'hFFFFFFFE}}, 32'hFFFFFFFF}, 8'h80};
        vecs[4] = '{256'h1_0000_0000, 256'h1, 3'b111, 256'hFFFFFFFF, 8'h00};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_ready", 256'(ready_o), 256'd0);
        chk("reset_valid", 256'(valid_o), 256'd0);
        chk("reset_diff", diff_o, 256'd0);
        chk("reset_borrow", 256'(borrow_o), 256'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", 256'(ready_o), 256'd1);
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_req(vecs[i].a, vecs[i].b, vecs[i].w, 0, 1'b0, d, br, lat);
            chk($sformatf("vec%0d_diff", i), d, vecs[i].d);
            chk($sformatf("vec%0d_borrow", i), 256'(br), 256'(vecs[i].br));
            chk($sformatf("vec%0d_latency", i), 256'(lat), 256'd9);
        end

        // Output stall with toggling inputs
        run_req(rand256(), rand256(), 3'b011, 5, 1'b1, d, br, lat);

        // Reset while chunk 4 is in flight
        a_i = rand256(); b_i = rand256(); width_i = 3'b001; valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_valid", 256'(valid_o), 256'd0);
        chk("midreset_ready", 256'(ready_o), 256'd0);
        chk("midreset_diff", diff_o, 256'd0);
        chk("midreset_borrow", 256'(borrow_o), 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            bit seen_valid;
            seen_valid = 1'b0;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (valid_o) seen_valid = 1'b1;
            end
            chk("midreset_no_valid", 256'(seen_valid), 256'd0);
            chk("midreset_ready_after", 256'(ready_o), 256'd1);
        end
        run_req(vecs[4].a, vecs[4].b, vecs[4].w, 0, 1'b0, d, br, lat);
        chk("after_reset_diff", d, vecs[4].d);
        chk("after_reset_borrow", 256'(br), 256'(vecs[4].br));

        // Random requests against the lane-level model
        for (int n = 0; n < 1000; n++) begin
            logic [255:0] ra, rb;
            logic [2:0]   rw;
            ra = rand256();
            rb = rand256();
            if ($urandom_range(0, 7) == 0) ra = rb;
            rw = legal[$urandom_range(0, 3)];
            ref_model(ra, rb, rw, ed, ebr);
            run_req(ra, rb, rw, int'($urandom_range(0, 3)), 1'b0, d, br, lat);
            chk("rand_diff", d, ed);
            chk("rand_borrow", 256'(br), 256'(ebr));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
